rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource between 8 requesters, using the same index-encoding convention as the team's 8-to-3 priority encoder (one-hot bit i ↔ index i). It sits between the requester bank and the shared resource: it samples requests, issues one-hot and encoded grants, holds each grant until the owner releases it or a hold limit expires, then rotates priority so no requester starves.

---
 rtl/rr_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 89 ++++++++
 tb/tb_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Handshake bundle between the requester bank and the round-robin arbiter.
// Requesters drive en/req/done; the arbiter drives the registered grant outputs.
interface rr_arbiter_if #(
    parameter int N  = 8,
    parameter int IW = 3
);
    logic          en;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          gnt_valid;
    logic          timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 8 requesters: one-hot plus encoded grant, held until
// done, withdrawal, disable or MAX_HOLD expiry, then priority rotates past the owner.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IW       = 3,
    parameter int MAX_HOLD = 16
) (
    input logic        clk,
    input logic        rst_n,
    rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [7:0]    hold_cnt;

    logic [IW-1:0] sel;
    logic          sel_found;
    logic [IW-1:0] idx;
    logic          owner_req;
    logic          hold_expired;
    logic          release_now;

    // Search ptr, ptr+1, ... wrapping; the IW-bit add gives the mod-N wrap for free.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + IW'(k);
            if (!sel_found && bus.req[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    assign owner_req    = bus.req[bus.gnt_id];
    assign hold_expired = (hold_cnt == 8'(MAX_HOLD));
    assign release_now  = !bus.en || bus.done || !owner_req || hold_expired;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
            ptr           <= '0;
            hold_cnt      <= '0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && sel_found) begin
                        state         <= GRANT;
                        bus.gnt       <= N'(1) << sel;
                        bus.gnt_id    <= sel;
                        bus.gnt_valid <= 1'b1;
                        hold_cnt      <= 8'd1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.gnt_id    <= '0;
                        bus.gnt_valid <= 1'b0;
                        hold_cnt      <= '0;
                        ptr           <= bus.gnt_id + IW'(1);
                        // Flag a timeout only when expiry alone caused the release.
                        bus.timeout   <= hold_expired && bus.en && !bus.done && owner_req;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus random traffic,
// each cycle compared against an owner/pointer reference model.
module tb_rr_arbiter;

    localparam int N        = 8;
    localparam int IW       = 3;
    localparam int MAX_HOLD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.N(N), .IW(IW)) bus ();

    rr_arbiter #(.N(N), .IW(IW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 = idle), rotation pointer, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_tout;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tout  = 1'b0;
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_tout = 1'b0;
        if (m_owner < 0) begin
            if (bus.en) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (bus.req[i]) begin
                        m_owner = i;
                        m_hold  = 1;
                        break;
                    end
                end
            end
        end else begin
            bit gone    = !bus.req[m_owner];
            bit expired = (m_hold == MAX_HOLD);
            if (!bus.en || bus.done || gone || expired) begin
                m_tout  = expired && bus.en && !bus.done && !gone;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endfunction

    function automatic logic [12:0] expv();
        logic [7:0] g;
        logic [2:0] id;
        g  = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
        id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        return {g, id, (m_owner >= 0), m_tout};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        bus.en   = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 13'h0);
        end
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (obs() !== {8'h01, 3'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%h exp=%h", obs(), {8'h01, 3'd0, 2'b10});
        end
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_model got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i <= N; i++) begin
            n_checks++;
            if (obs() !== {8'(1) << (i % N), 3'(i % N), 2'b10}) begin
                n_fail++;
                $display("FAIL fair_grant_%0d got=%h exp=%h", i, obs(), {8'(1) << (i % N), 3'(i % N), 2'b10});
            end
            bus.done = 1'b1;
            cycle();
            n_checks++;
            if (obs() !== 13'h0) begin
                n_fail++;
                $display("FAIL fair_idle_%0d got=%h exp=%h", i, obs(), 13'h0);
            end
            bus.done = 1'b0;
            cycle();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL fair_model_%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_rotation_skip();
        bus.done = 1'b1;
        cycle();
        bus.done = 1'b0;
        cycle();
        n_checks++;
        if (obs() !== {8'h04, 3'd2, 2'b10}) begin
            n_fail++;
            $display("FAIL skip_owner2 got=%h exp=%h", obs(), {8'h04, 3'd2, 2'b10});
        end
        bus.done = 1'b1;
        bus.req  = 8'b0000_0101;
        cycle();
        bus.done = 1'b0;
        cycle();
        n_checks++;
        if (obs() !== {8'h01, 3'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL skip_wrap got=%h exp=%h", obs(), {8'h01, 3'd0, 2'b10});
        end
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL skip_model got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_timeout();
        int held = 0;
        bus.en = 1'b0;
        cycle();
        bus.en   = 1'b1;
        bus.req  = 8'h10;
        bus.done = 1'b0;
        cycle();
        while (bus.gnt_valid === 1'b1 && held < 40) begin
            n_checks++;
            if (obs() !== expv() || bus.gnt !== 8'h10) begin
                n_fail++;
                $display("FAIL timeout_hold_%0d got=%h exp=%h", held, obs(), expv());
            end
            held++;
            cycle();
        end
        n_checks++;
        if (held != MAX_HOLD) begin
            n_fail++;
            $display("FAIL timeout_length got=%0d exp=%0d", held, MAX_HOLD);
        end
        n_checks++;
        if (obs() !== {8'h00, 3'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL timeout_pulse got=%h exp=%h", obs(), {8'h00, 3'd0, 2'b01});
        end
        cycle();
        n_checks++;
        if (obs() !== {8'h10, 3'd4, 2'b10}) begin
            n_fail++;
            $display("FAIL timeout_regrant got=%h exp=%h", obs(), {8'h10, 3'd4, 2'b10});
        end
    endtask

    task automatic test_abort_withdraw();
        bus.en = 1'b0;
        cycle();
        bus.en  = 1'b1;
        bus.req = 8'h08;
        cycle();
        n_checks++;
        if (obs() !== {8'h08, 3'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL abort_grant3 got=%h exp=%h", obs(), {8'h08, 3'd3, 2'b10});
        end
        cycle();
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (obs() !== 13'h0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL abort_idle_%0d got=%h exp=%h", i, obs(), 13'h0);
            end
        end
        bus.en = 1'b1;
        cycle();
        n_checks++;
        if (obs() !== {8'h08, 3'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL withdraw_grant3 got=%h exp=%h", obs(), {8'h08, 3'd3, 2'b10});
        end
        bus.req = 8'h00;
        cycle();
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL withdraw_release got=%h exp=%h", obs(), 13'h0);
        end
        bus.req = 8'h18;
        cycle();
        n_checks++;
        if (obs() !== {8'h10, 3'd4, 2'b10}) begin
            n_fail++;
            $display("FAIL withdraw_ptr4 got=%h exp=%h", obs(), {8'h10, 3'd4, 2'b10});
        end
    endtask

    task automatic test_async_reset();
        bus.req = 8'h00;
        cycle();
        bus.req = 8'h20;
        cycle();
        n_checks++;
        if (obs() !== {8'h20, 3'd5, 2'b10}) begin
            n_fail++;
            $display("FAIL areset_grant5 got=%h exp=%h", obs(), {8'h20, 3'd5, 2'b10});
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 13'h0) begin
            n_fail++;
            $display("FAIL areset_immediate got=%h exp=%h", obs(), 13'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = 8'hFF;
        cycle();
        n_checks++;
        if (obs() !== {8'h01, 3'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL areset_ptr0 got=%h exp=%h", obs(), {8'h01, 3'd0, 2'b10});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) bus.req = 8'($urandom);
            cycle();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_model_%0d got=%h exp=%h", i, obs(), expv());
            end
            n_checks++;
            if ($countones(bus.gnt) > 1 || bus.gnt_valid !== (|bus.gnt) ||
                (bus.gnt !== 8'h00 && bus.gnt !== (8'(1) << bus.gnt_id)) ||
                (bus.gnt === 8'h00 && bus.gnt_id !== 3'd0)) begin
                n_fail++;
                $display("FAIL random_invariant_%0d got=%h", i, obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_rotation_skip();
        test_timeout();
        test_abort_withdraw();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
